// File: rtl/const_mult_pkg.sv
// Shared types and constants for the sequential saturating left-shift multiplier.
package const_mult_pkg;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/lsh1_sat_step.sv
// One signed left-shift step: doubles the value, or clamps it when the
// doubling would leave the 16-bit signed range.
module lsh1_sat_step
    import const_mult_pkg::*;
(
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf
);
    // Doubling keeps the sign only while the top two bits agree.
    assign ovf = val[WIDTH-1] ^ val[WIDTH-2];
    assign nxt = ovf ? (val[WIDTH-1] ? SAT_NEG : SAT_POS)
                     : {val[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/constant_multiplier_16bit_lsh_seq.sv
// Sequential signed multiply by 2^shamt, one shift per cycle, saturating on
// overflow, with valid/ready handshakes on input and output.
module constant_multiplier_16bit_lsh_seq
    import const_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow
);
    state_t           state, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_ovf;

    lsh1_sat_step u_step (
        .val (val_q),
        .nxt (step_nxt),
        .ovf (step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            val_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_d;
            val_q <= val_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        val_d   = val_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    val_d   = in_data;
                    cnt_d   = shamt;
                    ovf_d   = 1'b0;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                val_d = step_nxt;
                // Saturation ends the operation early; remaining shifts are moot.
                if (step_ovf) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads low for the whole reset pulse.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? val_q : '0;
    assign overflow  = (state == DONE) && ovf_q;
endmodule

// File: tb/tb_constant_multiplier_16bit_lsh_seq.sv
// Directed bench for the sequential saturating left-shift multiplier.
module tb_constant_multiplier_16bit_lsh_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    constant_multiplier_16bit_lsh_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    typedef struct {
        logic [15:0] din;
        logic [3:0]  sh;
        logic [15:0] dout;
        logic        ovf;
        int          lat;   // negedges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with in_valid already high; returns after the accepting posedge.
    task automatic wait_accept(input string name);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Counts negedges until out_valid is seen; 0 means it never came.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = v.din;
        shamt     = v.sh;
        out_ready = 1'b1;
        wait_accept(name);
        #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        shamt    = 4'hF;
        wait_valid(n);
        chk({name, "_latency"},  n,        v.lat);
        chk({name, "_out_data"}, out_data, v.dout);
        chk({name, "_overflow"}, overflow, v.ovf);
        @(negedge clk);
        chk({name, "_valid_one_cycle"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        logic seen_valid;

        vecs[0]  = '{16'h0003, 4'd4,  16'h0030, 1'b0, 5};
        vecs[1]  = '{16'hFFFF, 4'd15, 16'h8000, 1'b0, 16};
        vecs[2]  = '{16'h0100, 4'd8,  16'h7FFF, 1'b1, 8};
        vecs[3]  = '{16'h8001, 4'd1,  16'h8000, 1'b1, 2};
        vecs[4]  = '{16'h1234, 4'd0,  16'h1234, 1'b0, 1};
        vecs[5]  = '{16'h0000, 4'd15, 16'h0000, 1'b0, 16};
        vecs[6]  = '{16'hC000, 4'd1,  16'h8000, 1'b0, 2};
        vecs[7]  = '{16'h4000, 4'd1,  16'h7FFF, 1'b1, 2};
        vecs[8]  = '{16'hF800, 4'd3,  16'hC000, 1'b0, 4};
        vecs[9]  = '{16'h0001, 4'd14, 16'h4000, 1'b0, 15};
        vecs[10] = '{16'h0001, 4'd15, 16'h7FFF, 1'b1, 16};
        vecs[11] = '{16'h8000, 4'd0,  16'h8000, 1'b0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        shamt     = 4'd0;
        out_ready = 1'b0;
        #1;
        chk("reset_in_ready",  in_ready,  1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data",  out_data,  16'h0000);
        chk("reset_overflow",  overflow,  1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure with a new word waiting upstream
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 16'h0003;
        shamt     = 4'd2;
        out_ready = 1'b0;
        wait_accept("bp");
        #1;
        in_data = 16'h0005;
        shamt   = 4'd1;
        wait_valid(n);
        chk("bp_latency", n, 3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {in_ready, out_valid, overflow, out_data},
                {1'b0, 1'b1, 1'b0, 16'h000C});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {in_ready, out_valid}, {1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp_next_latency", n, 2);
        chk("bp_next_data", out_data, 16'h000A);
        chk("bp_next_ovf", overflow, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a shift sequence
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        shamt    = 4'd10;
        wait_accept("rst");
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, out_valid, overflow, out_data}, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_stale_valid", seen_valid, 1'b0);
        run_vec("after_rst", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
